// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte buffer behind the UART receiver. Holds up to DEPTH bytes
// in a circular FIFO and presents them to the consumer through a
// first-word-fall-through valid/ready interface. A sticky overflow flag
// records any byte dropped because the consumer fell behind.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_valid, wr_data byte strobe and value from the UART receiver
//   rd_ready          consumer takes rd_data this cycle
//   rd_valid, rd_data oldest byte (8'h00 when empty)
//   count             entries held, 0..DEPTH
//   empty, full       count == 0 / count == DEPTH
//   almost_full       count >= AFULL_THRESH
//   overflow          sticky drop flag, cleared by clr_overflow
module uart_rx_fifo #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned AFULL_THRESH = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [7:0]        wr_data,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [7:0]        rd_data,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              overflow,
  input  logic              clr_overflow
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C = (ADDR_W+1)'(AFULL_THRESH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push;
  logic              pop;

  // Flags decode the registered count, so rd_ready never reaches rd_valid.
  assign empty       = (count == '0);
  assign full        = (count == DEPTH_C);
  assign almost_full = (count >= AFULL_C);
  assign rd_valid    = !empty;
  assign rd_data     = empty ? 8'h00 : mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign pop  = !empty && rd_ready;
  assign push = wr_valid && (!full || pop);

  // Storage: not reset, contents are invalidated by the pointers instead.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
      // A new drop wins over a coincident clear.
      if (wr_valid && full && !pop) overflow <= 1'b1;
      else if (clr_overflow)        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a vector table for short sequences,
// hand-written fill/overflow/drain and reset sequences, and a randomized phase
// compared against a queue-based reference model.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_ready = 1'b0;
  logic       clr_overflow = 1'b0;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [4:0] count;
  logic       empty, full, almost_full, overflow;

  uart_rx_fifo #(.DEPTH(16), .ADDR_W(4), .AFULL_THRESH(12)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .count(count), .empty(empty), .full(full), .almost_full(almost_full),
    .overflow(overflow), .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a queue plus a sticky drop flag.
  logic [7:0] mq[$];
  bit         movf = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Apply one cycle of inputs, clock, update the model from the pre-edge state.
  task automatic cyc(input bit r, input bit wv, input logic [7:0] wd,
                     input bit rr, input bit clr);
    bit m_full, m_pop;
    rst = r; wr_valid = wv; wr_data = wd; rd_ready = rr; clr_overflow = clr;
    m_full = (mq.size() == 16);
    m_pop  = (mq.size() != 0) && rr;
    @(posedge clk);
    if (r) begin
      mq.delete();
      movf = 1'b0;
    end else begin
      if (wv && m_full && !m_pop) movf = 1'b1;
      else if (clr)               movf = 1'b0;
      if (m_pop) void'(mq.pop_front());
      if (wv && (!m_full || m_pop)) mq.push_back(wd);
    end
    #1;
    rst = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; clr_overflow = 1'b0;
  endtask

  task automatic check_model(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".rd_valid"},    int'(rd_valid),    int'(n != 0));
    chk({tag, ".rd_data"},     int'(rd_data),     (n != 0) ? int'(mq[0]) : 0);
    chk({tag, ".count"},       int'(count),       n);
    chk({tag, ".empty"},       int'(empty),       int'(n == 0));
    chk({tag, ".full"},        int'(full),        int'(n == 16));
    chk({tag, ".almost_full"}, int'(almost_full), int'(n >= 12));
    chk({tag, ".overflow"},    int'(overflow),    int'(movf));
  endtask

  typedef struct {
    bit         r, wv;
    logic [7:0] wd;
    bit         rr, clr;
    bit         ev;
    logic [7:0] ed;
    int         ec;
    bit         eo;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // r wv wd rr clr | rd_valid rd_data count overflow
    tbl[0] = '{1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0};  // reset
    tbl[1] = '{0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0};  // idle
    tbl[2] = '{0, 1, 8'h55, 0, 0, 1, 8'h55, 1, 0};  // single push
    tbl[3] = '{0, 0, 8'h00, 0, 0, 1, 8'h55, 1, 0};  // held stable
    tbl[4] = '{0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0};  // pop
    tbl[5] = '{0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0};  // rd_ready while empty
    tbl[6] = '{0, 1, 8'hA1, 0, 0, 1, 8'hA1, 1, 0};
    tbl[7] = '{0, 1, 8'hB2, 1, 0, 1, 8'hB2, 1, 0};  // push+pop
    tbl[8] = '{0, 1, 8'hC3, 0, 0, 1, 8'hB2, 2, 0};
    tbl[9] = '{1, 1, 8'hEE, 0, 0, 0, 8'h00, 0, 0};  // reset beats push

    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].wv, tbl[i].wd, tbl[i].rr, tbl[i].clr);
      chk($sformatf("vec%0d.rd_valid", i), int'(rd_valid), int'(tbl[i].ev));
      chk($sformatf("vec%0d.rd_data", i),  int'(rd_data),  int'(tbl[i].ed));
      chk($sformatf("vec%0d.count", i),    int'(count),    tbl[i].ec);
      chk($sformatf("vec%0d.empty", i),    int'(empty),    int'(tbl[i].ec == 0));
      chk($sformatf("vec%0d.overflow", i), int'(overflow), int'(tbl[i].eo));
    end

    // Fill 00..0F; almost_full tracks count >= 12, full at 16.
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 8'(i), 0, 0);
      chk($sformatf("fill%0d.count", i),       int'(count),       i + 1);
      chk($sformatf("fill%0d.almost_full", i), int'(almost_full), int'(i + 1 >= 12));
      chk($sformatf("fill%0d.full", i),        int'(full),        int'(i + 1 == 16));
    end
    // Drop 8'hAA.
    cyc(0, 1, 8'hAA, 0, 0);
    chk("ovf.overflow", int'(overflow), 1);
    chk("ovf.count",    int'(count),    16);
    chk("ovf.rd_data",  int'(rd_data),  8'h00);
    cyc(0, 0, 8'h00, 0, 1);
    chk("clr.overflow", int'(overflow), 0);
    // Full with push+pop: 8'hC3 lands in the freed slot, no drop.
    cyc(0, 1, 8'hC3, 1, 0);
    chk("fullpp.count",    int'(count),    16);
    chk("fullpp.overflow", int'(overflow), 0);
    chk("fullpp.rd_data",  int'(rd_data),  8'h01);
    // Drain: 01..0F then C3; AA never seen.
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("drain%0d.rd_data", i), int'(rd_data), (i == 16) ? 8'hC3 : i);
      cyc(0, 0, 8'h00, 1, 0);
    end
    chk("drained.empty", int'(empty), 1);
    chk("drained.count", int'(count), 0);

    // Mid-stream reset with 5 held.
    for (int i = 0; i < 5; i++) cyc(0, 1, 8'(8'h30 + i), 0, 0);
    chk("pre_rst.count", int'(count), 5);
    cyc(1, 0, 8'h00, 0, 0);
    chk("mid_rst.empty", int'(empty), 1);
    chk("mid_rst.count", int'(count), 0);
    chk("mid_rst.rd_valid", int'(rd_valid), 0);

    // Coincident clear and drop: set wins; clear alone then clears.
    for (int i = 0; i < 16; i++) cyc(0, 1, 8'(8'h80 + i), 0, 0);
    cyc(0, 1, 8'hF0, 0, 0);
    chk("ovf2.overflow", int'(overflow), 1);
    cyc(0, 1, 8'hF1, 0, 1);
    chk("setwins.overflow", int'(overflow), 1);
    chk("setwins.count",    int'(count),    16);
    cyc(0, 0, 8'h00, 0, 1);
    chk("clralone.overflow", int'(overflow), 0);
    check_model("post_clr");

    // Randomized traffic against the model; writes are held back when the
    // model is full so the flow never drops.
    cyc(1, 0, 8'h00, 0, 0);
    check_model("rnd_rst");
    begin
      int pushed = 0;
      int popped = 0;
      int guard  = 0;
      while ((pushed < 60 || mq.size() != 0) && guard < 2000) begin
        bit wv, rr;
        wv = (pushed < 60) && ($urandom_range(0, 99) < 55);
        rr = ($urandom_range(0, 99) < 45);
        if (mq.size() == 16 && !rr) wv = 1'b0;
        if (wv) pushed++;
        if (rr && mq.size() != 0) popped++;
        cyc(0, wv, 8'($urandom), rr, 0);
        check_model("rnd");
        chk("rnd.count_bound", int'(count <= 5'd16), 1);
        guard++;
      end
      chk("rnd.finished", int'(guard < 2000), 1);
      chk("rnd.all_popped", popped, 60);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
